// File: rtl/add_seq_32_bit.sv
`default_nettype none
// ============================================================================
// Module   : add_seq_32_bit
// Purpose  : Multi-cycle 32-bit add/subtract. One SLICE_W-bit ripple-carry
//            slice is reused over WIDTH/SLICE_W cycles, least-significant
//            slice first. A registered carry links each slice to the next.
//            Ready/valid handshakes are used on both the input and the
//            output side.
// Ports    : clk        - clock; all state updates on the rising edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - requester presents an operation
//            in_ready   - block can accept (IDLE only)
//            X, Y       - operands, sampled on the input handshake
//            ci         - carry-in for add (ignored when sub=1)
//            sub        - 0: X+Y+ci, 1: X-Y
//            out_valid  - result valid and held stable (DONE)
//            out_ready  - consumer accepts the result
//            sum        - result register
//            co         - final carry-out (for subtract, 1 = no borrow)
//            ovf        - signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module add_seq_32_bit #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8     // WIDTH must be an integer multiple of this
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q,   opa_d;
  logic [WIDTH-1:0]   opb_q,   opb_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               co_q,    co_d;
  logic               ovf_q,   ovf_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W:0]   slice_full;
  logic               slice_co;
  logic               slice_msb_cin;

  // Select the operand slice addressed by the counter.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        slice_a = opa_q[k*SLICE_W +: SLICE_W];
        slice_b = opb_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  // The shared ripple-carry slice.
  assign slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, carry_q};
  assign slice_co   = slice_full[SLICE_W];

  // Carry into the slice MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign slice_msb_cin = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_full[SLICE_W-1];

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    co_d      = co_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtract is X + ~Y + 1: invert B here and seed the carry with 1.
          opa_d   = X;
          opb_d   = sub ? ~Y : Y;
          carry_d = sub ? 1'b1 : ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < NSLICE; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            sum_d[k*SLICE_W +: SLICE_W] = slice_full[SLICE_W-1:0];
          end
        end
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          co_d    = slice_co;
          ovf_d   = slice_msb_cin ^ slice_co;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_add_seq_32_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_seq_32_bit
// Purpose  : Directed self-checking bench for add_seq_32_bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_seq_32_bit;

  localparam int NSLICE = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        co;
  logic        ovf;

  int vectors = 0;
  int fails   = 0;

  add_seq_32_bit #(.WIDTH(32), .SLICE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction: accept, RUN, DONE (optionally held), drain.
  task automatic run_op(input string tag,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic c, input logic s,
                        input logic [31:0] esum, input logic eco, input logic eovf,
                        input bit chk_carry, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    X = x; Y = y; ci = c; sub = s; in_valid = 1'b1;
    // Early out_ready must be ignored while RUN is in progress.
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = $urandom; Y = $urandom; ci = ~c; sub = ~s;
    chk({tag, "_busy"}, {in_ready, out_valid}, 2'b00);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (chk_carry) chk({tag, "_carry"}, dut.carry_q, 1'b1);
    end
    chk({tag, "_latency"}, lat, NSLICE);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_co"}, co, eco);
    chk({tag, "_ovf"}, ovf, eovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {in_ready, out_valid, sum, co, ovf}, {1'b0, 1'b1, esum, eco, eovf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    int acc [3];
    int na;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; X = '0; Y = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {out_valid, sum, co, ovf}, 35'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    run_op("add_simple", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 0);
    run_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
    run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0);
    run_op("neg_wrap", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 0);
    run_op("mixed", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    run_op("backpress", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0, 10);

    // Throughput: in_valid and out_ready held high, accepts every 6 cycles.
    X = 32'h0000_0001; Y = 32'h0000_0001; ci = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    na = 0;
    for (int i = 0; i < 40 && na < 3; i++) begin
      if (in_ready) begin
        acc[na] = i;
        na++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("thru_accepts", na, 3);
    chk("thru_gap1", acc[1] - acc[0], 6);
    chk("thru_gap2", acc[2] - acc[1], 6);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("thru_sum", sum, 32'h0000_0002);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("thru_idle", in_ready, 1'b1);

    // Reset during the second RUN cycle.
    X = 32'h1234_5678; Y = 32'h1111_1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("mid_pre_sum_nz", (sum != 32'd0), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {out_valid, sum, co, ovf}, 35'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    run_op("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
